// File: rtl/pfc_pkg.sv
// Shared types and constants for the pixel frame controller.
// Holds the sequencer state encoding, Bayer pattern and filter codes,
// and the output-counter width with its saturating increment helper.
package pfc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pfc_state_t;

  // Bayer sensor patterns
  localparam logic [1:0] RGGB = 2'b00;
  localparam logic [1:0] GRBG = 2'b01;
  localparam logic [1:0] GBRG = 2'b10;
  localparam logic [1:0] BGGR = 2'b11;

  // Pipeline filter types
  localparam logic [1:0] FILT_NONE = 2'b00;
  localparam logic [1:0] BLUR      = 2'b01;
  localparam logic [1:0] SHARPEN   = 2'b10;
  localparam logic [1:0] EDGE_DET  = 2'b11;

  localparam int OUT_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [OUT_CNT_W-1:0] sat_inc(input logic [OUT_CNT_W-1:0] v);
    return (&v) ? v : v + OUT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pfc_watchdog.sv
// Purpose: DRAIN idle watchdog, a loadable down-counter.
// Latency: expired rises on the (TIMEOUT-1)th enabled cycle after a reload, so the
// Backpressure: none; reload has priority over enable and restarts the count.
module pfc_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic reload,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Loading TIMEOUT-1 makes the sequencer reach DONE exactly TIMEOUT cycles
  // after the last reload event (last pipeline output or DRAIN entry).
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count down on idle cycles, restart on reload
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = en && (cnt <= CW'(1));

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Purpose: frame sequencer, reads one raster frame from a frame buffer into pixel_pipeline and counts outputs.
// Latency: read issued in cycle c appears as pipe_pixel_valid/pipe_raw_pixel in cycle c+2.
// Backpressure: pause stalls reads (address holds); optional DRAIN watchdog under PFC_WATCHDOG_EN.
module pixel_frame_ctrl
  import pfc_pkg::*;
#(
  parameter int IMG_W         = 64,
  parameter int IMG_H         = 64,
  parameter int ADDR_W        = 12,
  parameter int EXP_OUT       = IMG_W * IMG_H,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           cfg_pattern,
  input  logic [1:0]           cfg_filter,
  input  logic                 pause,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [7:0]           mem_rd_data,
  output logic [7:0]           pipe_raw_pixel,
  output logic                 pipe_pixel_valid,
  output logic [1:0]           pipe_sensor_pattern,
  output logic [1:0]           pipe_filter_type,
  input  logic                 pipe_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [OUT_CNT_W-1:0] out_count
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  pfc_state_t state, state_next;
  logic                 rd_d1, rd_d2;
  logic                 to_flag;
  logic                 counting;
  logic                 accept;
  logic                 frame_done;
  logic                 wd_expired;
  logic [OUT_CNT_W-1:0] cnt_next;

  assign accept   = (state == IDLE) && start;
  assign counting = (state == FEED) || (state == DRAIN);
  assign cnt_next = (counting && pipe_out_valid) ? sat_inc(out_count) : out_count;
  // Completion counts the output arriving this cycle, so it beats a same-cycle watchdog expiry
  assign frame_done = !rd_d1 && !rd_d2 && (int'(cnt_next) >= EXP_OUT);

`ifdef PFC_WATCHDOG_EN
  pfc_watchdog #(
    .TIMEOUT (DRAIN_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .en      ((state == DRAIN) && !pipe_out_valid),
    .reload  ((state != DRAIN) || pipe_out_valid),
    .expired (wd_expired)
  );
`else
  // No watchdog: DRAIN waits for the full output count indefinitely
  assign wd_expired = 1'b0 & (DRAIN_TIMEOUT != 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FEED;
      FEED:    if (!pause && (mem_rd_addr == LAST_ADDR)) state_next = DRAIN;
      DRAIN:   if (frame_done || wd_expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; the read strobe follows pause combinationally
  always_comb begin
    mem_rd_en   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      FEED: begin
        busy      = 1'b1;
        mem_rd_en = !pause;
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        done        = 1'b1;
        timeout_err = to_flag;
      end
      default: ;
    endcase
  end

  // Two-stage read-strobe delay and pixel capture matching the buffer's one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1          <= 1'b0;
      rd_d2          <= 1'b0;
      pipe_raw_pixel <= '0;
    end else begin
      rd_d1 <= mem_rd_en;
      rd_d2 <= rd_d1;
      if (rd_d1) pipe_raw_pixel <= mem_rd_data;
    end
  end

  assign pipe_pixel_valid = rd_d2;

  // Frame context: address, configuration latch, output count and timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_addr         <= '0;
      pipe_sensor_pattern <= '0;
      pipe_filter_type    <= '0;
      out_count           <= '0;
      to_flag             <= 1'b0;
    end else if (accept) begin
      mem_rd_addr         <= '0;
      pipe_sensor_pattern <= cfg_pattern;
      pipe_filter_type    <= cfg_filter;
      out_count           <= '0;
      to_flag             <= 1'b0;
    end else begin
      if (mem_rd_en) mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
      out_count <= cnt_next;
      if ((state == DRAIN) && !frame_done && wd_expired) to_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Self-checking bench for pixel_frame_ctrl on a 2x2 frame.
// A behavioural frame buffer and a fixed-latency echo pipeline surround the DUT.
// Expectations derive from read order, pause schedule and output budget.
module tb_pixel_frame_ctrl;
  import pfc_pkg::*;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int AW = 12;
  localparam int N  = W * H;
  localparam int TO = 8;
`ifdef PFC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, pause;
  logic [1:0]    cfg_pattern, cfg_filter;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic [7:0]    pipe_raw_pixel;
  logic          pipe_pixel_valid;
  logic [1:0]    pipe_sensor_pattern, pipe_filter_type;
  logic          pipe_out_valid;
  logic          busy, done, timeout_err;
  logic [15:0]   out_count;

  int            checks, errors;
  logic [7:0]    fb [N];
  bit            pause_sched [512];
  int            out_limit;
  logic [1:0]    prev_pat, prev_filt;
  int            prev_count;
  logic [7:0]    sh;
  int            given;

  always #5 clk = ~clk;

  pixel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .EXP_OUT(N), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_pattern(cfg_pattern), .cfg_filter(cfg_filter),
    .pause(pause), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pipe_raw_pixel(pipe_raw_pixel), .pipe_pixel_valid(pipe_pixel_valid),
    .pipe_sensor_pattern(pipe_sensor_pattern), .pipe_filter_type(pipe_filter_type),
    .pipe_out_valid(pipe_out_valid), .busy(busy), .done(done), .timeout_err(timeout_err),
    .out_count(out_count)
  );

  // Synchronous frame buffer: data one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= fb[mem_rd_addr[1:0]];
  end

  // Echo pipeline: each input pixel reappears 5 cycles later, up to out_limit per frame
  always @(posedge clk) begin
    if (reset) sh <= '0;
    else       sh <= {sh[6:0], pipe_pixel_valid};
    if (reset || (start && !busy)) given <= 0;
    else if (pipe_out_valid)       given <= given + 1;
  end
  assign pipe_out_valid = sh[4] && (given < out_limit);

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    prev_pat = '0; prev_filt = '0; prev_count = 0;
  endtask

  // One frame: start in cycle 0, then per-cycle comparison against the frame-level model
  task automatic run_frame(input string tag, input logic [1:0] pat, input logic [1:0] filt,
                           input int limit, input int drain_poke, input bit chain);
    int rd_cyc [N];
    int k, c, nout, last_rd, last_out, exp_done, ncyc, poke_cyc, exp_cnt;
    bit exp_to, exp_rd, exp_vld, exp_busy;
    logic [7:0] exp_px;
    logic [1:0] exp_pat, exp_filt;
    c = 1; k = 0;
    while (k < N && c < 511) begin
      if (!pause_sched[c]) begin rd_cyc[k] = c; k++; end
      c++;
    end
    last_rd  = rd_cyc[N-1];
    nout     = (limit < N) ? limit : N;
    last_out = rd_cyc[nout-1] + 7;
    exp_to   = 1'b0;
    if (nout == N) exp_done = last_out + 1;
    else if (WD) begin
      exp_done = ((last_out > last_rd) ? last_out : last_rd) + TO;
      exp_to   = 1'b1;
    end else exp_done = -1;
    ncyc     = (exp_done < 0) ? 200 : (chain ? exp_done + 1 : exp_done + 3);
    poke_cyc = (drain_poke >= 0) ? last_rd + 1 + drain_poke : -1;
    out_limit = limit;
    k = 0;
    for (int cy = 0; cy < ncyc; cy++) begin
      @(posedge clk); #1;
      start       = (cy == 0) || (cy == poke_cyc) || (chain && cy == exp_done);
      cfg_pattern = (cy == 0) ? pat  : BGGR;
      cfg_filter  = (cy == 0) ? filt : SHARPEN;
      pause       = pause_sched[cy];
      @(negedge clk);
      exp_rd = (k < N) && (rd_cyc[k] == cy);
      checks++;
      if (mem_rd_en !== exp_rd) begin
        errors++; $display("FAIL %s rd_en cyc %0d: got %b want %b", tag, cy, mem_rd_en, exp_rd);
      end
      if (cy >= 1 && k < N) begin
        checks++;
        if (mem_rd_addr !== AW'(k)) begin
          errors++; $display("FAIL %s rd_addr cyc %0d: got %0d want %0d", tag, cy, mem_rd_addr, k);
        end
      end
      if (exp_rd) k++;
      exp_vld = 1'b0; exp_px = '0;
      for (int i = 0; i < N; i++) if (rd_cyc[i] + 2 == cy) begin exp_vld = 1'b1; exp_px = fb[i]; end
      checks++;
      if (pipe_pixel_valid !== exp_vld) begin
        errors++; $display("FAIL %s pix_valid cyc %0d: got %b want %b", tag, cy, pipe_pixel_valid, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (pipe_raw_pixel !== exp_px) begin
          errors++; $display("FAIL %s pixel cyc %0d: got %02h want %02h", tag, cy, pipe_raw_pixel, exp_px);
        end
      end
      exp_cnt = 0;
      if (cy == 0) exp_cnt = prev_count;
      else for (int i = 0; i < nout; i++) if (rd_cyc[i] + 7 < cy) exp_cnt++;
      checks++;
      if (out_count !== 16'(exp_cnt)) begin
        errors++; $display("FAIL %s out_count cyc %0d: got %0d want %0d", tag, cy, out_count, exp_cnt);
      end
      checks++;
      if (done !== (cy == exp_done)) begin
        errors++; $display("FAIL %s done cyc %0d: got %b want %b", tag, cy, done, (cy == exp_done));
      end
      checks++;
      if (timeout_err !== (cy == exp_done && exp_to)) begin
        errors++; $display("FAIL %s timeout_err cyc %0d: got %b want %b", tag, cy, timeout_err, (cy == exp_done && exp_to));
      end
      exp_busy = (cy >= 1) && (exp_done < 0 || cy < exp_done);
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL %s busy cyc %0d: got %b want %b", tag, cy, busy, exp_busy);
      end
      exp_pat  = (cy == 0) ? prev_pat  : pat;
      exp_filt = (cy == 0) ? prev_filt : filt;
      checks++;
      if ({pipe_sensor_pattern, pipe_filter_type} !== {exp_pat, exp_filt}) begin
        errors++; $display("FAIL %s cfg cyc %0d: got %b/%b want %b/%b", tag, cy,
                           pipe_sensor_pattern, pipe_filter_type, exp_pat, exp_filt);
      end
    end
    start = 1'b0; pause = 1'b0;
    prev_pat = pat; prev_filt = filt; prev_count = nout;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({mem_rd_en, pipe_pixel_valid, busy, done, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL %s flags: got %b want 00000", tag,
                         {mem_rd_en, pipe_pixel_valid, busy, done, timeout_err});
    end
    checks++;
    if (mem_rd_addr !== '0) begin errors++; $display("FAIL %s rd_addr: got %0d want 0", tag, mem_rd_addr); end
    checks++;
    if (pipe_raw_pixel !== 8'h00) begin errors++; $display("FAIL %s raw_pixel: got %02h want 00", tag, pipe_raw_pixel); end
    checks++;
    if (out_count !== 16'h0) begin errors++; $display("FAIL %s out_count: got %0d want 0", tag, out_count); end
    checks++;
    if ({pipe_sensor_pattern, pipe_filter_type} !== 4'b0) begin
      errors++; $display("FAIL %s cfg: got %b/%b want 00/00", tag, pipe_sensor_pattern, pipe_filter_type);
    end
  endtask

  task automatic clear_pause();
    for (int i = 0; i < 512; i++) pause_sched[i] = 1'b0;
  endtask

  task automatic load_fixed_frame();
    fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'hFF;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
  endtask

  task automatic test_basic();
    load_fixed_frame(); clear_pause();
    run_frame("basic", RGGB, BLUR, N, -1, 1'b0);
  endtask

  task automatic test_pause();
    load_fixed_frame(); clear_pause();
    pause_sched[3] = 1'b1; pause_sched[4] = 1'b1; pause_sched[5] = 1'b1;
    run_frame("pause", RGGB, BLUR, N, -1, 1'b0);
  endtask

  task automatic test_drain_start();
    load_fixed_frame(); clear_pause();
    run_frame("drain_start", RGGB, BLUR, N, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) fb[i] = 8'(8'h30 + i);
    clear_pause();
    run_frame("b2b_first", GRBG, SHARPEN, N, -1, 1'b1);
    run_frame("b2b_second", GBRG, EDGE_DET, N, -1, 1'b0);
  endtask

  task automatic test_timeout();
    load_fixed_frame(); clear_pause();
    run_frame(WD ? "timeout" : "no_watchdog_hang", RGGB, BLUR, N - 1, -1, 1'b0);
    apply_reset();
  endtask

  task automatic test_reset_mid_feed();
    bit seen_done;
    for (int i = 0; i < N; i++) fb[i] = 8'($urandom);
    clear_pause();
    @(posedge clk); #1;
    start = 1'b1; cfg_pattern = BGGR; cfg_filter = SHARPEN;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_feed");
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL reset_mid_feed_quiet: got done/busy=1 want 0"); end
    prev_pat = '0; prev_filt = '0; prev_count = 0;
    run_frame("after_reset", GRBG, BLUR, N, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] pats  [4];
    logic [1:0] filts [4];
    pats  = '{RGGB, GRBG, GBRG, BGGR};
    filts = '{FILT_NONE, BLUR, SHARPEN, EDGE_DET};
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) fb[i] = 8'($urandom);
      clear_pause();
      for (int c = 1; c <= 40; c++) pause_sched[c] = ($urandom_range(0, 2) == 0);
      run_frame("random", pats[$urandom_range(0, 3)], filts[$urandom_range(0, 3)],
                N, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    cfg_pattern = '0; cfg_filter = '0;
    out_limit = N; prev_pat = '0; prev_filt = '0; prev_count = 0;
    clear_pause();
    test_reset();
    test_basic();
    test_pause();
    test_drain_start();
    test_back_to_back();
    test_timeout();
    test_reset_mid_feed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
